// File: rtl/noise_estimation_stream_if.sv
// rtl/noise_estimation_stream_if.sv - pixel beat stream into the noise estimator
interface noise_estimation_stream_if #(
    parameter int DATA_WIDTH = 8,
    parameter int LANES      = 4
);
    logic                          in_valid;
    logic                          in_ready;
    logic [LANES*DATA_WIDTH-1:0]   in_data;
    logic                          start_of_frame;

    modport master (output in_valid, in_data, start_of_frame, input in_ready);
    modport slave  (input in_valid, in_data, start_of_frame, output in_ready);
endinterface

// File: rtl/noise_estimation_stream.sv
// rtl/noise_estimation_stream.sv - per-block variance and per-frame noise estimate
module noise_estimation_stream #(
    parameter int DATA_WIDTH      = 8,
    parameter int LANES           = 4,
    parameter int BLOCK_SIZE      = 8,
    parameter int MAX_LOG2_BLOCKS = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    noise_estimation_stream_if.slave stream,
    input  logic [4:0]              blocks_per_frame_log2,
    input  logic                    mode_min,
    output logic [2*DATA_WIDTH-1:0] block_var,
    output logic                    block_var_valid,
    output logic [2*DATA_WIDTH-1:0] estimated_noise,
    output logic                    estimated_noise_ready,
    output logic                    frame_abort,
    output logic                    busy
);
    localparam int N     = BLOCK_SIZE * BLOCK_SIZE;
    localparam int LOG2N = $clog2(N);
    localparam int BEATS = N / LANES;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int DW    = DATA_WIDTH;
    localparam int VW    = 2 * DATA_WIDTH;
    localparam int SW    = DATA_WIDTH + LOG2N;
    localparam int QW    = 2 * DATA_WIDTH + LOG2N;
    localparam int AW    = 2 * DATA_WIDTH + MAX_LOG2_BLOCKS;
    localparam int CW    = MAX_LOG2_BLOCKS + 1;

    typedef enum logic [2:0] {IDLE, ACCUM, BLK_VAR, BLK_UPD, FRAME_DONE} state_t;

    state_t          state;
    logic            ready_q;
    logic [SW-1:0]   sum;
    logic [QW-1:0]   sumsq;
    logic [BW-1:0]   beat_cnt;
    logic [CW-1:0]   blk_cnt;
    logic [AW-1:0]   frame_acc;
    logic [VW-1:0]   frame_min;
    logic [4:0]      bpf_q;
    logic            mode_q;

    logic [SW-1:0]   lane_sum;
    logic [QW-1:0]   lane_sq;
    logic [DW-1:0]   mean_v;
    logic [VW-1:0]   msq_v;
    logic [VW-1:0]   mm_v;
    logic [VW-1:0]   var_v;
    logic [CW-1:0]   blk_cnt_next;
    logic            frame_last;
    logic            accept;
    logic [4:0]      bpf_in;

    assign stream.in_ready = ready_q;
    assign accept          = stream.in_valid & ready_q;
    assign bpf_in          = (blocks_per_frame_log2 > 5'(MAX_LOG2_BLOCKS)) ?
                             5'(MAX_LOG2_BLOCKS) : blocks_per_frame_log2;

    always_comb begin
        lane_sum = '0;
        lane_sq  = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_sum = lane_sum + SW'(stream.in_data[i*DW +: DW]);
            lane_sq  = lane_sq + QW'(stream.in_data[i*DW +: DW]) * QW'(stream.in_data[i*DW +: DW]);
        end
    end

    // floor(mean)^2 never exceeds floor(sumsq/N), the clamp only guards the subtraction
    always_comb begin
        mean_v = DW'(sum >> LOG2N);
        msq_v  = VW'(sumsq >> LOG2N);
        mm_v   = VW'(mean_v) * VW'(mean_v);
        var_v  = (msq_v > mm_v) ? (msq_v - mm_v) : '0;
    end

    assign blk_cnt_next = blk_cnt + CW'(1);
    assign frame_last   = (blk_cnt_next == (CW'(1) << bpf_q));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state                 <= IDLE;
            ready_q               <= 1'b0;
            sum                   <= '0;
            sumsq                 <= '0;
            beat_cnt              <= '0;
            blk_cnt               <= '0;
            frame_acc             <= '0;
            frame_min             <= '0;
            bpf_q                 <= '0;
            mode_q                <= 1'b0;
            block_var             <= '0;
            block_var_valid       <= 1'b0;
            estimated_noise       <= '0;
            estimated_noise_ready <= 1'b0;
            frame_abort           <= 1'b0;
            busy                  <= 1'b0;
        end else begin
            block_var_valid       <= 1'b0;
            estimated_noise_ready <= 1'b0;
            frame_abort           <= 1'b0;
            case (state)
                IDLE, ACCUM: begin
                    ready_q <= 1'b1;
                    if (accept && stream.start_of_frame) begin
                        // a start beat always opens a fresh frame as beat 0
                        frame_abort <= (state == ACCUM);
                        mode_q      <= mode_min;
                        bpf_q       <= bpf_in;
                        blk_cnt     <= '0;
                        frame_acc   <= '0;
                        frame_min   <= '0;
                        busy        <= 1'b1;
                        sum         <= lane_sum;
                        sumsq       <= lane_sq;
                        if (BEATS == 1) begin
                            beat_cnt <= '0;
                            state    <= BLK_VAR;
                            ready_q  <= 1'b0;
                        end else begin
                            beat_cnt <= BW'(1);
                            state    <= ACCUM;
                        end
                    end else if (accept && state == ACCUM) begin
                        sum   <= sum + lane_sum;
                        sumsq <= sumsq + lane_sq;
                        if (beat_cnt == BW'(BEATS - 1)) begin
                            beat_cnt <= '0;
                            state    <= BLK_VAR;
                            ready_q  <= 1'b0;
                        end else begin
                            beat_cnt <= beat_cnt + BW'(1);
                        end
                    end
                end
                BLK_VAR: begin
                    block_var       <= var_v;
                    block_var_valid <= 1'b1;
                    state           <= BLK_UPD;
                end
                BLK_UPD: begin
                    if (mode_q) begin
                        if (blk_cnt == '0 || block_var < frame_min)
                            frame_min <= block_var;
                    end else begin
                        frame_acc <= frame_acc + AW'(block_var);
                    end
                    sum      <= '0;
                    sumsq    <= '0;
                    beat_cnt <= '0;
                    blk_cnt  <= blk_cnt_next;
                    if (frame_last) begin
                        state <= FRAME_DONE;
                    end else begin
                        state   <= ACCUM;
                        ready_q <= 1'b1;
                    end
                end
                FRAME_DONE: begin
                    estimated_noise       <= mode_q ? frame_min : VW'(frame_acc >> bpf_q);
                    estimated_noise_ready <= 1'b1;
                    busy                  <= 1'b0;
                    state                 <= IDLE;
                    ready_q               <= 1'b1;
                end
                default: begin
                    state   <= IDLE;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_noise_estimation_stream.sv
// tb/tb_noise_estimation_stream.sv - scoreboard bench for noise_estimation_stream
module tb_noise_estimation_stream;
    localparam int DW = 8;
    localparam int L  = 4;
    localparam int N  = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  bpf = '0;
    logic        mode_min = 1'b0;
    logic [15:0] block_var, estimated_noise;
    logic        block_var_valid, estimated_noise_ready, frame_abort, busy;

    noise_estimation_stream_if #(.DATA_WIDTH(DW), .LANES(L)) bus ();

    noise_estimation_stream #(.DATA_WIDTH(DW), .LANES(L), .BLOCK_SIZE(8), .MAX_LOG2_BLOCKS(16)) dut (
        .clk(clk), .rst_n(rst_n), .stream(bus),
        .blocks_per_frame_log2(bpf), .mode_min(mode_min),
        .block_var(block_var), .block_var_valid(block_var_valid),
        .estimated_noise(estimated_noise), .estimated_noise_ready(estimated_noise_ready),
        .frame_abort(frame_abort), .busy(busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int blk_q[$];
    int noise_q[$];
    int abort_exp = 0;

    int mdl_pix[$];
    int mdl_vars[$];
    int m_log2 = 0;
    int m_mode = 0;
    bit m_in_frame = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // variance of a block straight from its definition: E[x^2] - E[x]^2 with floors
    function automatic int block_variance(input int px[$]);
        int s = 0, q = 0, m, r;
        foreach (px[i]) begin
            s += px[i];
            q += px[i] * px[i];
        end
        m = s / N;
        r = q / N - m * m;
        return (r < 0) ? 0 : r;
    endfunction

    function automatic int model_beat(input logic [L*DW-1:0] d, input bit sof);
        int v, acc, mn;
        if (sof) begin
            if (m_in_frame) abort_exp++;
            mdl_pix.delete();
            mdl_vars.delete();
            m_log2 = int'(bpf);
            m_mode = int'(mode_min);
            m_in_frame = 1'b1;
        end else if (!m_in_frame) begin
            return 0;
        end
        for (int i = 0; i < L; i++) mdl_pix.push_back(int'(d[i*DW +: DW]));
        if (mdl_pix.size() < N) return 0;
        v = block_variance(mdl_pix);
        mdl_pix.delete();
        blk_q.push_back(v);
        mdl_vars.push_back(v);
        if (mdl_vars.size() < (1 << m_log2)) return 1;
        acc = 0;
        mn = mdl_vars[0];
        foreach (mdl_vars[i]) begin
            acc += mdl_vars[i];
            if (mdl_vars[i] < mn) mn = mdl_vars[i];
        end
        noise_q.push_back(m_mode ? mn : (acc >> m_log2));
        m_in_frame = 1'b0;
        return 2;
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            if (block_var_valid) begin
                if (blk_q.size() == 0) chk("unexpected_block_var_valid", 1, 0);
                else chk("block_var", int'(block_var), blk_q.pop_front());
            end
            if (estimated_noise_ready) begin
                if (noise_q.size() == 0) chk("unexpected_noise_ready", 1, 0);
                else chk("estimated_noise", int'(estimated_noise), noise_q.pop_front());
            end
            if (frame_abort) begin
                chk("frame_abort_expected", int'(abort_exp > 0), 1);
                if (abort_exp > 0) abort_exp--;
            end
        end
    end

    function automatic int pix(input int pattern, input int blk, input int idx);
        int chkr;
        chkr = (((idx / 8) + (idx % 8)) % 2) ? 16 : 0;
        case (pattern)
            0: return 100;
            1: return chkr;
            2: return (blk % 2 == 0) ? chkr : 100;
            3: return int'($urandom_range(0, 255));
            default: return int'($urandom_range(90, 110));
        endcase
    endfunction

    task automatic send_beat(input logic [L*DW-1:0] d, input bit sof, input bit gaps);
        bit r;
        int res, guard;
        if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
                bus.in_valid = 1'b0;
                bus.in_data = $urandom;
                @(negedge clk);
            end
        end
        bus.in_valid = 1'b1;
        bus.in_data = d;
        bus.start_of_frame = sof;
        guard = 0;
        forever begin
            r = bus.in_ready;
            @(posedge clk);
            if (r) break;
            @(negedge clk);
            guard++;
            if (guard > 50) begin
                chk("accept_timeout", 0, 1);
                break;
            end
        end
        res = model_beat(d, sof);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.start_of_frame = 1'b0;
        if (sof && res == 0) chk("busy_after_start", int'(busy), 1);
        if (res > 0) begin
            chk("ready_low_1", int'(bus.in_ready), 0);
            chk("bvv_not_yet", int'(block_var_valid), 0);
            bus.in_valid = 1'b1;
            bus.in_data = $urandom;
            @(negedge clk);
            chk("ready_low_2", int'(bus.in_ready), 0);
            chk("bvv_latency", int'(block_var_valid), 1);
            bus.in_data = $urandom;
            @(negedge clk);
            bus.in_valid = 1'b0;
            if (res == 1) begin
                chk("ready_back_high", int'(bus.in_ready), 1);
            end else begin
                chk("ready_low_frame_done", int'(bus.in_ready), 0);
                chk("noise_not_yet", int'(estimated_noise_ready), 0);
                @(negedge clk);
                chk("noise_latency", int'(estimated_noise_ready), 1);
                chk("busy_falls", int'(busy), 0);
            end
        end
    endtask

    task automatic send_frame(input int log2, input int mode, input int pattern,
                              input bit gaps, input int limit);
        int beats;
        logic [L*DW-1:0] d;
        beats = (1 << log2) * (N / L);
        if (limit >= 0 && limit < beats) beats = limit;
        bpf = 5'(log2);
        mode_min = mode[0];
        for (int b = 0; b < beats; b++) begin
            for (int i = 0; i < L; i++) d[i*DW +: DW] = 8'(pix(pattern, b / (N / L), (b % (N / L)) * L + i));
            send_beat(d, b == 0, gaps);
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_block_var"}, int'(block_var), 0);
        chk({tag, "_noise"}, int'(estimated_noise), 0);
        chk({tag, "_pulses"}, int'({block_var_valid, estimated_noise_ready, frame_abort}), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_ready"}, int'(bus.in_ready), 0);
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.start_of_frame = 1'b0;
        repeat (3) @(negedge clk);
        check_zero_outputs("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        send_frame(0, 0, 0, 1'b0, -1);
        send_frame(0, 0, 1, 1'b0, -1);
        send_frame(2, 0, 2, 1'b0, -1);
        send_frame(2, 1, 2, 1'b0, -1);
        send_frame(2, 1, 1, 1'b0, -1);
        send_frame(0, 1, 1, 1'b1, -1);
        for (int k = 0; k < 6; k++)
            send_frame(int'($urandom_range(0, 2)), int'($urandom_range(0, 1)), 3 + (k % 2), 1'b1, -1);

        send_frame(1, 0, 3, 1'b0, 5);
        send_frame(1, 1, 3, 1'b1, -1);

        send_frame(1, 0, 3, 1'b1, 5);
        rst_n = 1'b0;
        mdl_pix.delete();
        mdl_vars.delete();
        m_in_frame = 1'b0;
        #1;
        check_zero_outputs("midframe_reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        send_frame(0, 0, 4, 1'b1, -1);

        repeat (10) @(negedge clk);
        chk("block_queue_drained", blk_q.size(), 0);
        chk("noise_queue_drained", noise_q.size(), 0);
        chk("abort_drained", abort_exp, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/noise_estimation_stream.md
Name: noise_estimation_stream

Overview:
Streaming, parametrised successor to the single-lane noise estimator. It accepts LANES luma pixels per beat over a valid/ready handshake and computes the variance of each BLOCK_SIZE x BLOCK_SIZE block. Per-block variances are then reduced over a frame to one noise estimate, either the mean or the minimum of the block variances. It sits between the RGB-mean stage and the Wiener-filter control, and replaces the gated-clock enable scheme with backpressure.

Parameters:
DATA_WIDTH, 8, pixel width in bits.
LANES, 4, pixels per input beat; power of 2 and must divide BLOCK_SIZE*BLOCK_SIZE.
BLOCK_SIZE, 8, block edge in pixels; power of 2. N = BLOCK_SIZE^2, LOG2N = log2(N).
MAX_LOG2_BLOCKS, 16, maximum log2 of the blocks-per-frame count.

Ports:
clk  in  1  clock.
rst_n  in  1  asynchronous active-low reset.
in_valid  in  1  input beat valid.
in_ready  out  1  block can accept a beat.
in_data  in  LANES*DATA_WIDTH  pixels; lane 0 is in the LSBs.
start_of_frame  in  1  marks the first beat of a frame; qualified by in_valid & in_ready.
blocks_per_frame_log2  in  5  log2 of blocks per frame; sampled when start_of_frame is accepted.
mode_min  in  1  0 = mean of block variances, 1 = minimum; sampled when start_of_frame is accepted.
block_var  out  2*DATA_WIDTH  variance of the last completed block.
block_var_valid  out  1  one-cycle pulse when block_var updates.
estimated_noise  out  2*DATA_WIDTH  frame noise estimate; held until the next frame result.
estimated_noise_ready  out  1  one-cycle pulse when estimated_noise updates.
frame_abort  out  1  one-cycle pulse when a frame is restarted mid-frame.
busy  out  1  high from an accepted start_of_frame until estimated_noise_ready.

Behaviour:
- Reset: every output register is 0, in_ready = 0 while rst_n is low, state = IDLE. Reset asserted mid-frame discards all accumulators; no result pulse is produced.
- States and transitions:
  - IDLE (in_ready = 1): beats without start_of_frame are accepted and dropped. An accepted beat with start_of_frame latches the mode inputs, clears the accumulators, counts as beat 0, and moves to ACCUM.
  - ACCUM (in_ready = 1): on each accepted beat, sum += sum of the lane pixels and sumsq += sum of the lane squares. The beat counter wraps at N/LANES. On the final beat of a block, go to BLK_VAR.
  - BLK_VAR (in_ready = 0): mean = sum >> LOG2N (floor); var = (sumsq >> LOG2N) - mean*mean, clamped at 0 and registered into block_var; block_var_valid pulses. Go to BLK_UPD.
  - BLK_UPD (in_ready = 0): in mean mode, frame_acc += block_var; in min mode, frame_min = min(frame_min, block_var), where the first block of a frame loads frame_min directly. Clear sum, sumsq and the beat counter, then increment the block counter.
    - If block counter == 2^blocks_per_frame_log2, go to FRAME_DONE.
    - Otherwise go to ACCUM.
  - FRAME_DONE (in_ready = 0, one cycle): estimated_noise = frame_acc >> blocks_per_frame_log2 (mean mode) or frame_min (min mode); estimated_noise_ready pulses; busy falls. Go to IDLE.
- Latency: if the final beat of a block is accepted at cycle t, block_var_valid occurs at t+1 and in_ready is low during t+1 and t+2. For the last block of a frame, estimated_noise_ready occurs at t+3.
- Widths:
  - sum: DATA_WIDTH + LOG2N bits.
  - sumsq: 2*DATA_WIDTH + LOG2N bits.
  - frame_acc: 2*DATA_WIDTH + MAX_LOG2_BLOCKS bits.
  - All arithmetic is unsigned and cannot overflow.
  - The squares and the lane adder tree are combinational within one cycle.
- start_of_frame accepted while in ACCUM: frame_abort pulses, the current frame is discarded, and the beat begins a new frame as beat 0 with the inputs re-latched. A start_of_frame arriving while in_ready = 0 is not accepted; the source must hold it.
- in_data is ignored when in_valid = 0. Holding in_valid low mid-block stalls the accumulation without loss of data.
- blocks_per_frame_log2 = 0 means a one-block frame: estimated_noise equals that block's variance in either mode.

Test Plan:
- Constant block (mean mode, LANES=4, BLOCK_SIZE=8, blocks_per_frame_log2=0): 16 beats of all pixels = 100 -> block_var = 0, estimated_noise = 0, estimated_noise_ready pulses 3 cycles after the last beat.
- Checkerboard block (pixels alternate 0 and 16, same configuration) -> mean 8, sumsq>>6 = 128, block_var = 64, estimated_noise = 64.
- Four-block frame in mean mode (blocks_per_frame_log2=2), block variances 64, 0, 64, 0 -> estimated_noise = 32; block_var_valid pulses exactly 4 times.
- Same four blocks with mode_min=1 -> estimated_noise = 0. Then a frame with variances 64, 64, 64, 64 -> estimated_noise = 64 (checks that the first block loads frame_min).
- Backpressure and stalls: random in_valid gaps mid-block give identical results. in_ready is low exactly 2 cycles after each block-final beat, and in_data presented during those cycles is not consumed.
- Aborts:
  - start_of_frame after 5 beats -> frame_abort pulse, then correct results for the new frame.
  - rst_n low for 1 cycle mid-frame -> all outputs return to 0 and there is no estimated_noise_ready until a full new frame completes.
